sign_extender: RTL and testbench

SIGN_EXTENDER -- requirements
Module: sign_extender

---
 rtl/sign_ext_pkg.sv | 15 +
 rtl/sext_core.sv | 41 ++++
 rtl/sign_extender.sv | 51 +++++
 tb/tb_sign_extender.sv | 113 +++++++++++
 4 files changed

// File: rtl/sign_ext_pkg.sv
// Shared definitions for the immediate sign/zero extender.
// Holds the mode encodings and the default field and datapath widths.
package sign_ext_pkg;

  localparam int DEF_IN_W  = 12;
  localparam int DEF_OUT_W = 16;

  typedef enum logic [1:0] {
    SEXT_FULL = 2'b00,
    ZEXT_FULL = 2'b01,
    SEXT_8    = 2'b10,
    SEXT_6    = 2'b11
  } ext_mode_e;

endpackage

// File: rtl/sext_core.sv
// Combinational extension of an immediate field to the datapath width.
// Each output bit selects its source bit, or the field's sign bit, from the mode.
module sext_core
  import sign_ext_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic [IN_W-1:0]  data_in,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] data_ext
);

  // The narrow modes read bits 7 and 5, so the field must be at least 8 wide.
  if (IN_W < 8) begin : g_bad_in_w
    $error("sext_core: IN_W (%0d) must be at least 8", IN_W);
  end

  for (genvar gi = 0; gi < OUT_W; gi++) begin : g_bit
    // Above the field, the source index clamps to the field's top bit.
    localparam int FULL_SRC = (gi < IN_W) ? gi : IN_W - 1;
    localparam int S8_SRC   = (gi < 8)    ? gi : 7;
    localparam int S6_SRC   = (gi < 6)    ? gi : 5;
    localparam bit IN_FIELD = (gi < IN_W);

    logic zext_bit;
    assign zext_bit = IN_FIELD ? data_in[FULL_SRC] : 1'b0;

    always_comb begin
      data_ext[gi] = data_in[FULL_SRC];
      case (mode)
        SEXT_FULL: data_ext[gi] = data_in[FULL_SRC];
        ZEXT_FULL: data_ext[gi] = zext_bit;
        SEXT_8:    data_ext[gi] = data_in[S8_SRC];
        SEXT_6:    data_ext[gi] = data_in[S6_SRC];
        default:   data_ext[gi] = data_in[FULL_SRC];
      endcase
    end
  end

endmodule

// File: rtl/sign_extender.sv
// Immediate extender: combinational extension core followed by one register
// stage, so results appear exactly one clock after a valid input.
module sign_extender
  import sign_ext_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  data_in,
  input  logic             valid_in,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] data_out,
  output logic             valid_out
);

  if (OUT_W <= IN_W) begin : g_bad_w
    $error("sign_extender: OUT_W (%0d) must exceed IN_W (%0d)", OUT_W, IN_W);
  end

  logic [OUT_W-1:0] data_next;
  logic [OUT_W-1:0] data_reg;
  logic             valid_reg;

  sext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .data_in  (data_in),
    .mode     (mode),
    .data_ext (data_next)
  );

  // Data only loads on valid cycles so an idle cycle keeps the last result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= valid_in;
      if (valid_in) begin
        data_reg <= data_next;
      end
    end
  end

  assign data_out  = data_reg;
  assign valid_out = valid_reg;

endmodule

// File: tb/tb_sign_extender.sv
// Directed bench for sign_extender with hand-computed expected words.
module tb_sign_extender;

  logic        clk;
  logic        rst_n;
  logic [11:0] data_in;
  logic        valid_in;
  logic [1:0]  mode;
  logic [15:0] data_out;
  logic        valid_out;

  int n_cmp = 0;
  int n_err = 0;

  sign_extender #(
    .IN_W  (12),
    .OUT_W (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .mode      (mode),
    .data_out  (data_out),
    .valid_out (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%04h", tag, got);
    end
  endtask

  // Present one valid input, then check the registered result after the edge.
  task automatic apply(input string tag, input logic [1:0] m, input logic [11:0] d,
                       input logic [15:0] exp);
    mode     = m;
    data_in  = d;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    check_val({tag, ".data"}, data_out, exp);
    check_val({tag, ".valid"}, {15'd0, valid_out}, 16'h0001);
  endtask

  initial begin
    rst_n    = 1'b0;
    data_in  = 12'h000;
    valid_in = 1'b0;
    mode     = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check_val("reset.data", data_out, 16'h0000);
    check_val("reset.valid", {15'd0, valid_out}, 16'h0000);
    #2 rst_n = 1'b1;

    // Back-to-back stream over all modes and the mode-00 boundaries.
    apply("m00_018", 2'b00, 12'h018, 16'h0018);
    apply("m00_818", 2'b00, 12'h818, 16'hF818);
    apply("m01_818", 2'b01, 12'h818, 16'h0818);
    apply("m10_F80", 2'b10, 12'hF80, 16'hFF80);
    apply("m11_020", 2'b11, 12'h020, 16'hFFE0);
    apply("m11_FDF", 2'b11, 12'hFDF, 16'h001F);
    apply("m00_7FF", 2'b00, 12'h7FF, 16'h07FF);
    apply("m00_800", 2'b00, 12'h800, 16'hF800);
    apply("m00_FFF", 2'b00, 12'hFFF, 16'hFFFF);
    apply("m00_000", 2'b00, 12'h000, 16'h0000);
    apply("m01_FFF", 2'b01, 12'hFFF, 16'h0FFF);
    apply("m10_A7F", 2'b10, 12'hA7F, 16'h007F);
    apply("m11_03F", 2'b11, 12'h03F, 16'hFFFF);

    // Four-deep stream then idle: data must hold the last result.
    apply("str0", 2'b00, 12'h001, 16'h0001);
    apply("str1", 2'b01, 12'h900, 16'h0900);
    apply("str2", 2'b10, 12'h081, 16'hFF81);
    apply("str3", 2'b11, 12'h015, 16'h0015);
    valid_in = 1'b0;
    mode     = 2'b00;
    data_in  = 12'h8AB;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check_val($sformatf("idle%0d.valid", i), {15'd0, valid_out}, 16'h0000);
      check_val($sformatf("idle%0d.data", i), data_out, 16'h0015);
    end

    // Async reset mid-cycle with a result in flight.
    apply("pre_rst", 2'b00, 12'h818, 16'hF818);
    data_in = 12'h7FF;
    #2 rst_n = 1'b0;
    #1;
    check_val("async_rst.data", data_out, 16'h0000);
    check_val("async_rst.valid", {15'd0, valid_out}, 16'h0000);
    @(posedge clk);
    #1;
    check_val("held_rst.data", data_out, 16'h0000);
    check_val("held_rst.valid", {15'd0, valid_out}, 16'h0000);
    #2 rst_n = 1'b1;
    apply("post_rst", 2'b00, 12'h018, 16'h0018);
    apply("post_rst2", 2'b00, 12'h800, 16'hF800);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
